// File: rtl/hs_pkg.sv
// Shared types and helpers for the two-phase handshake scheduler family.
package hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_t;

  localparam int HS_SYNC_STAGES = 2;
  localparam int HS_MAX_N       = 8;

  // First set bit of vec at or after ptr, wrapping modulo n (n <= HS_MAX_N, ptr < n).
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr,
                                         input logic [HS_MAX_N-1:0] vec,
                                         input int n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < HS_MAX_N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && vec[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hs_sync.sv
// Single-bit multi-stage synchroniser, synchronously cleared to 0.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hs_rr_sched.sv
// Round-robin scheduler sharing one two-phase req/ack/dat channel among N
// two-phase upstream channels. All outputs are registered.
module hs_rr_sched
  import hs_pkg::*;
#(
  parameter int N           = 2,
  parameter int SYNC_STAGES = HS_SYNC_STAGES,
  localparam int SW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  mask,
  input  logic [N-1:0]  in_req,
  output logic [N-1:0]  in_ack,
  input  logic [N-1:0]  in_dat,
  output logic          out_req,
  input  logic          out_ack,
  output logic          out_dat,
  output logic [SW-1:0] sel,
  output logic          busy,
  output hs_state_t     state
);

  // Two-phase handshake: a channel is pending while req level != ack level;
  // the receiver completes it by toggling ack to match req. Every level resets to 0.

  logic [N-1:0]  req_s;
  logic          ack_s;
  logic [N-1:0]  pending;
  logic [N-1:0]  elig;
  logic [HS_MAX_N-1:0] elig_vec;
  logic [SW-1:0] pick;

  hs_state_t     state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel_d;
  logic [N-1:0]  in_ack_d;
  logic          out_req_d, out_dat_d, busy_d;

  for (genvar g = 0; g < N; g++) begin : g_req_sync
    hs_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (in_req[g]),
      .q   (req_s[g])
    );
  end

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (out_ack),
    .q   (ack_s)
  );

  assign pending = req_s ^ in_ack;
  assign elig    = pending & ~mask;

  always_comb begin
    elig_vec         = '0;
    elig_vec[N-1:0]  = elig;
    pick             = SW'(rr_pick(3'(ptr_q), elig_vec, N));
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel;
    in_ack_d  = in_ack;
    out_req_d = out_req;
    out_dat_d = out_dat;
    busy_d    = busy;
    case (state_q)
      IDLE: begin
        if (en && (elig != '0)) begin
          sel_d     = pick;
          out_dat_d = in_dat[pick];
          out_req_d = ~out_req;
          busy_d    = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (ack_s == out_req) begin
          in_ack_d[sel] = ~in_ack[sel];
          ptr_d         = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);
          busy_d        = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel     <= '0;
      in_ack  <= '0;
      out_req <= 1'b0;
      out_dat <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel     <= sel_d;
      in_ack  <= in_ack_d;
      out_req <= out_req_d;
      out_dat <= out_dat_d;
      busy    <= busy_d;
    end
  end

  assign state = state_q;

endmodule
